alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter that lets two ExecutionFSM-style requesters share one VectorALU. It sits between the execution FSMs and the ALU. Each requester's operation and operands are captured on a one-cycle request pulse. The arbiter issues one ALU operation at a time with a single-cycle trigger, then routes the ALU's results and branch flags back to the requester that owns the operation.

## Interface
- WIDTH, 32, width of one ALU channel or result word
- OP_WIDTH, 16, width of the ALU operation code

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- iReq0 / iReq1  in  1  one-cycle request pulse from requester 0 / 1
- iOp0 / iOp1  in  OP_WIDTH  operation code, sampled only in the iReqN cycle
- iOperands0 / iOperands1  in  6*WIDTH  channels {X1,X2,Y1,Y2,Z1,Z2}, MSB first, sampled only in the iReqN cycle
- oALUTrigger  out  1  one-cycle trigger to the ALU input-ready pin
- oALUOperation  out  OP_WIDTH  registered operation to the ALU
- oALUOperands  out  6*WIDTH  registered channels to the ALU, same packing as iOperandsN
- iALUOutputReady  in  1  ALU completion pulse
- iALUResult  in  3*WIDTH  ALU result {X,Y,Z}
- iALUBranchTaken / iALUBranchNotTaken  in  1  ALU branch flags, valid with iALUOutputReady
- oResult  out  3*WIDTH  captured result, held until the next completion
- oBranchTaken / oBranchNotTaken  out  1  captured flags, held with oResult
- oDone0 / oDone1  out  1  one-cycle completion pulse to the owning requester
- oBusy0 / oBusy1  out  1  requester N has a pending or in-flight operation
- oError  out  1  sticky protocol-error flag, cleared only by Reset

## Operation
- Per-requester slot: pending flag plus an op/operand capture register.
  - iReqN while slot N is free: capture iOpN/iOperandsN and set pending.
  - iReqN while oBusyN=1: ignored, slot unchanged, oError set.
- Priority bit prio selects the preferred requester; reset value 0.
- State machine:
  - IDLE: if no pending flag is set, stay. If one is set, grant it. If both are set, grant the requester named by prio. On grant, load the winner's op/operands into oALUOperation/oALUOperands, clear its pending flag, record owner, go to ISSUE.
  - ISSUE: oALUTrigger=1 for exactly this cycle, go to WAIT.
  - WAIT: on iALUOutputReady, register iALUResult and both branch flags into oResult/oBranchTaken/oBranchNotTaken, pulse oDone[owner] next cycle, set prio to ~owner, go to IDLE.
- oBusyN = pendingN | (owner==N while state≠IDLE) | oDoneN cycle. It drops the cycle after oDoneN.
- iALUOutputReady in IDLE or ISSUE: ignored, oError set.
- A request pulse in the same cycle as that requester's oDoneN is accepted as a new request.
- Only one operation is in flight; there are no result FIFOs.

## Timing
- Reset values: state IDLE, prio 0, pending flags 0, and all outputs 0 (oALUOperation, oALUOperands, oResult, flags, pulses, oBusyN, oError).
- Reset mid-operation: in-flight and pending work is discarded and no oDone is emitted. The ALU is reset by the same Reset.
- Latency with the arbiter idle:
  - iReqN at cycle t.
  - Grant at t+1.
  - oALUTrigger at t+2.
  - iALUOutputReady at cycle u ≥ t+3.
  - oDoneN and valid oResult at u+1.
- Back-to-back: a second pending request is granted at u+1 and triggered at u+2. Minimum trigger spacing is 3 cycles.
- oALUOperation/oALUOperands are stable from the ISSUE cycle until the next grant.

## Test plan
- Single request: iReq0 with op=ADD, operands X1=1,X2=2, ALU model replies 3 cycles after trigger with X=3 → oALUTrigger at t+2; oDone0 one cycle after OutputReady; oResult X=3; oDone1 never asserted.
- Simultaneous requests after reset: iReq0 and iReq1 in the same cycle → requester 0 served first, then requester 1. Next tie is won by requester 0 again, because prio=~owner=0 after serving 1.
- Alternation under load: both requesters re-request on every oDone for 8 operations → grants strictly alternate 0,1,0,1…; trigger spacing ≥ 3 cycles.
- Protocol errors: second iReq1 while oBusy1=1, then a spurious iALUOutputReady in IDLE → first op completes normally with its original operands; oError=1 and stays 1 until Reset.
- Branch routing: requester 1 op returns BranchTaken=1 → oBranchTaken=1 with oDone1, held after the next completion's flags overwrite only.
- Reset in WAIT: assert Reset with an op in flight and the other pending → all outputs 0 next cycle, no oDone pulses; a fresh iReq1 afterwards completes normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lets two execution FSMs share one vector ALU.
// It captures requests, issues one ALU operation at a time and routes the results back to the owner.
module alu_share_arbiter #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReq0,
    input  logic                  iReq1,
    input  logic [OP_WIDTH-1:0]   iOp0,
    input  logic [OP_WIDTH-1:0]   iOp1,
    input  logic [6*WIDTH-1:0]    iOperands0,
    input  logic [6*WIDTH-1:0]    iOperands1,
    output logic                  oALUTrigger,
    output logic [OP_WIDTH-1:0]   oALUOperation,
    output logic [6*WIDTH-1:0]    oALUOperands,
    input  logic                  iALUOutputReady,
    input  logic [3*WIDTH-1:0]    iALUResult,
    input  logic                  iALUBranchTaken,
    input  logic                  iALUBranchNotTaken,
    output logic [3*WIDTH-1:0]    oResult,
    output logic                  oBranchTaken,
    output logic                  oBranchNotTaken,
    output logic                  oDone0,
    output logic                  oDone1,
    output logic                  oBusy0,
    output logic                  oBusy1,
    output logic                  oError
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                pending0;
    logic                pending1;
    logic [OP_WIDTH-1:0] op0;
    logic [OP_WIDTH-1:0] op1;
    logic [6*WIDTH-1:0]  operands0;
    logic [6*WIDTH-1:0]  operands1;
    logic                prio;
    logic                owner;
    logic                grant;
    logic                winner;
    logic                complete;
    logic                in_flight0;
    logic                in_flight1;
    logic                accept0;
    logic                accept1;
    logic                protocol_error;

    assign in_flight0 = (state != IDLE) && !owner;
    assign in_flight1 = (state != IDLE) && owner;

    // A request landing on the oDone cycle is accepted, so the done pulse is not part of "occupied".
    assign accept0 = iReq0 && !pending0 && !in_flight0;
    assign accept1 = iReq1 && !pending1 && !in_flight1;

    assign protocol_error = (iReq0 && !accept0) || (iReq1 && !accept1) ||
                            (iALUOutputReady && (state != WAIT));

    assign oBusy0 = pending0 | in_flight0 | oDone0;
    assign oBusy1 = pending1 | in_flight1 | oDone1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        winner      = 1'b0;
        complete    = 1'b0;
        oALUTrigger = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending0 || pending1) begin
                    grant      = 1'b1;
                    winner     = (pending0 && pending1) ? prio : pending1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                oALUTrigger = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (iALUOutputReady) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending0        <= 1'b0;
            pending1        <= 1'b0;
            op0             <= '0;
            op1             <= '0;
            operands0       <= '0;
            operands1       <= '0;
            prio            <= 1'b0;
            owner           <= 1'b0;
            oALUOperation   <= '0;
            oALUOperands    <= '0;
            oResult         <= '0;
            oBranchTaken    <= 1'b0;
            oBranchNotTaken <= 1'b0;
            oDone0          <= 1'b0;
            oDone1          <= 1'b0;
            oError          <= 1'b0;
        end else begin
            oDone0 <= 1'b0;
            oDone1 <= 1'b0;

            if (accept0) begin
                pending0  <= 1'b1;
                op0       <= iOp0;
                operands0 <= iOperands0;
            end
            if (accept1) begin
                pending1  <= 1'b1;
                op1       <= iOp1;
                operands1 <= iOperands1;
            end

            // A grant only ever clears a set pending flag, so it never collides with a same-slot accept.
            if (grant) begin
                owner <= winner;
                if (winner) begin
                    oALUOperation <= op1;
                    oALUOperands  <= operands1;
                    pending1      <= 1'b0;
                end else begin
                    oALUOperation <= op0;
                    oALUOperands  <= operands0;
                    pending0      <= 1'b0;
                end
            end

            if (complete) begin
                oResult         <= iALUResult;
                oBranchTaken    <= iALUBranchTaken;
                oBranchNotTaken <= iALUBranchNotTaken;
                oDone0          <= !owner;
                oDone1          <= owner;
                prio            <= ~owner;
            end

            if (protocol_error) begin
                oError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: table-driven single requests plus hand-written sequences.
// A single process drives stimulus, models the ALU and scores completions against per-requester queues.
module tb_alu_share_arbiter;

    localparam int WIDTH    = 32;
    localparam int OP_WIDTH = 16;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 16'h0001;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 16'h0002;
    localparam logic [OP_WIDTH-1:0] OP_BEQ = 16'h0003;

    typedef struct {
        logic [3*WIDTH-1:0] res;
        logic               bt;
        logic               bnt;
    } exp_t;

    typedef struct {
        int                  id;
        logic [OP_WIDTH-1:0] op;
        logic [6*WIDTH-1:0]  opnds;
        int                  delay;
        logic [3*WIDTH-1:0]  res;
        logic                bt;
        logic                bnt;
    } vec_t;

    logic                Clock;
    logic                Reset;
    logic                iReq0;
    logic                iReq1;
    logic [OP_WIDTH-1:0] iOp0;
    logic [OP_WIDTH-1:0] iOp1;
    logic [6*WIDTH-1:0]  iOperands0;
    logic [6*WIDTH-1:0]  iOperands1;
    logic                oALUTrigger;
    logic [OP_WIDTH-1:0] oALUOperation;
    logic [6*WIDTH-1:0]  oALUOperands;
    logic                iALUOutputReady;
    logic [3*WIDTH-1:0]  iALUResult;
    logic                iALUBranchTaken;
    logic                iALUBranchNotTaken;
    logic [3*WIDTH-1:0]  oResult;
    logic                oBranchTaken;
    logic                oBranchNotTaken;
    logic                oDone0;
    logic                oDone1;
    logic                oBusy0;
    logic                oBusy1;
    logic                oError;

    logic                alu_ready;
    logic                tb_spurious;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_trig   = -1;
    int last_ready  = -1;
    int last_done   = -1;
    int alu_cnt     = 0;
    int alu_delay   = 3;
    logic [OP_WIDTH-1:0] alu_op;
    logic [6*WIDTH-1:0]  alu_opnds;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   order_q[$];

    assign iALUOutputReady = alu_ready | tb_spurious;

    alu_share_arbiter #(
        .WIDTH    (WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .iReq0              (iReq0),
        .iReq1              (iReq1),
        .iOp0               (iOp0),
        .iOp1               (iOp1),
        .iOperands0         (iOperands0),
        .iOperands1         (iOperands1),
        .oALUTrigger        (oALUTrigger),
        .oALUOperation      (oALUOperation),
        .oALUOperands       (oALUOperands),
        .iALUOutputReady    (iALUOutputReady),
        .iALUResult         (iALUResult),
        .iALUBranchTaken    (iALUBranchTaken),
        .iALUBranchNotTaken (iALUBranchNotTaken),
        .oResult            (oResult),
        .oBranchTaken       (oBranchTaken),
        .oBranchNotTaken    (oBranchNotTaken),
        .oDone0             (oDone0),
        .oDone1             (oDone1),
        .oBusy0             (oBusy0),
        .oBusy1             (oBusy1),
        .oError             (oError)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [6*WIDTH-1:0] pack6(input logic [WIDTH-1:0] x1, x2, y1, y2, z1, z2);
        return {x1, x2, y1, y2, z1, z2};
    endfunction

    // Reference ALU: ADD/SUB per channel, BEQ compares X1 with X2 and returns {X1^X2, Y1, Z1}.
    function automatic exp_t alu_model(input logic [OP_WIDTH-1:0] op, input logic [6*WIDTH-1:0] v);
        exp_t e;
        logic [WIDTH-1:0] x1, x2, y1, y2, z1, z2;
        {x1, x2, y1, y2, z1, z2} = v;
        e.res = '0;
        e.bt  = 1'b0;
        e.bnt = 1'b0;
        case (op)
            OP_ADD: e.res = {x1 + x2, y1 + y2, z1 + z2};
            OP_SUB: e.res = {x1 - x2, y1 - y2, z1 - z2};
            OP_BEQ: begin
                e.res = {x1 ^ x2, y1, z1};
                e.bt  = (x1 == x2);
                e.bnt = (x1 != x2);
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic report_fail(input string name, input string msg);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Advance one cycle, then run the ALU model and score anything the DUT produced.
    task automatic tick();
        exp_t e;
        int   id;
        @(posedge Clock);
        #1;
        cyc++;
        iReq0       = 1'b0;
        iReq1       = 1'b0;
        tb_spurious = 1'b0;
        iOp0        = OP_WIDTH'($urandom);
        iOp1        = OP_WIDTH'($urandom);
        iOperands0  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        iOperands1  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        if (Reset) begin
            alu_cnt   = 0;
            alu_ready = 1'b0;
        end else begin
            alu_ready = 1'b0;
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    e                  = alu_model(alu_op, alu_opnds);
                    iALUResult         = e.res;
                    iALUBranchTaken    = e.bt;
                    iALUBranchNotTaken = e.bnt;
                    alu_ready          = 1'b1;
                    last_ready         = cyc;
                end
            end
            if (oALUTrigger) begin
                if (last_trig >= 0)
                    check_output("trigger_spacing", 128'((cyc - last_trig) >= 3), 128'(1));
                last_trig = cyc;
                alu_op    = oALUOperation;
                alu_opnds = oALUOperands;
                alu_cnt   = alu_delay;
            end
        end

        if (oDone0 || oDone1) begin
            check_output("single_done", 128'(oDone0 && oDone1), 128'(0));
            id        = oDone1 ? 1 : 0;
            last_done = cyc;
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                report_fail("unexpected_done", $sformatf("oDone%0d with no outstanding request", id));
            end else begin
                e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check_output($sformatf("result%0d", id), 128'(oResult), 128'(e.res));
                check_output($sformatf("branch_taken%0d", id), 128'(oBranchTaken), 128'(e.bt));
                check_output($sformatf("branch_not_taken%0d", id), 128'(oBranchNotTaken), 128'(e.bnt));
                order_q.push_back(id);
            end
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [OP_WIDTH-1:0] op,
                                  input logic [6*WIDTH-1:0] opnds, input exp_t e, input bit accept);
        if (id == 0) begin
            iReq0      = 1'b1;
            iOp0       = op;
            iOperands0 = opnds;
            if (accept) exp_q0.push_back(e);
        end else begin
            iReq1      = 1'b1;
            iOp1       = op;
            iOperands1 = opnds;
            if (accept) exp_q1.push_back(e);
        end
    endtask

    task automatic request(input int id, input logic [OP_WIDTH-1:0] op, input logic [6*WIDTH-1:0] opnds);
        apply_stimulus(id, op, opnds, alu_model(op, opnds), 1'b1);
    endtask

    task automatic clear_scoreboard();
        exp_q0.delete();
        exp_q1.delete();
        order_q.delete();
        last_trig = -1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || oBusy0 || oBusy1) && n < budget) begin
            tick();
            n++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0 || oBusy0 || oBusy1) begin
            report_fail(name, "timeout waiting for completions");
            exp_q0.delete();
            exp_q1.delete();
        end
    endtask

    task automatic check_order(input int exp_id, input string name);
        if (order_q.size() == 0) report_fail(name, "no completion recorded");
        else check_output(name, 128'(order_q.pop_front()), 128'(exp_id));
    endtask

    task automatic check_zero_outputs(input string name);
        check_output({name, "_flags"},
                     128'({oALUTrigger, oBranchTaken, oBranchNotTaken, oDone0, oDone1, oBusy0, oBusy1, oError}),
                     128'(0));
        check_output({name, "_operation"}, 128'(oALUOperation), 128'(0));
        check_output({name, "_operands"}, 128'(oALUOperands), 128'(0));
        check_output({name, "_result"}, 128'(oResult), 128'(0));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        check_zero_outputs("reset");
        tick();
        Reset = 1'b0;
        clear_scoreboard();
    endtask

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   req_cyc;
        int   issued;
        int   budget;

        Reset              = 1'b1;
        iReq0              = 1'b0;
        iReq1              = 1'b0;
        iOp0               = '0;
        iOp1               = '0;
        iOperands0         = '0;
        iOperands1         = '0;
        iALUResult         = '0;
        iALUBranchTaken    = 1'b0;
        iALUBranchNotTaken = 1'b0;
        alu_ready          = 1'b0;
        tb_spurious        = 1'b0;
        alu_op             = '0;
        alu_opnds          = '0;

        vecs[0] = '{0, OP_ADD, pack6(32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0), 3,
                    {32'd3, 32'd0, 32'd0}, 1'b0, 1'b0};
        vecs[1] = '{1, OP_SUB, pack6(32'd10, 32'd4, 32'd7, 32'd9, 32'd100, 32'd1), 1,
                    {32'd6, 32'hFFFF_FFFE, 32'd99}, 1'b0, 1'b0};
        vecs[2] = '{0, OP_BEQ, pack6(32'd5, 32'd5, 32'd11, 32'd0, 32'd22, 32'd0), 2,
                    {32'd0, 32'd11, 32'd22}, 1'b1, 1'b0};
        vecs[3] = '{1, OP_BEQ, pack6(32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0), 5,
                    {32'd3, 32'd0, 32'd0}, 1'b0, 1'b1};
        vecs[4] = '{1, OP_ADD, pack6(32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'd3, 32'd4), 3,
                    {32'd0, 32'd0, 32'd7}, 1'b0, 1'b0};
        vecs[5] = '{0, OP_SUB, pack6(32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0), 4,
                    {32'hFFFF_FFFF, 32'd0, 32'd0}, 1'b0, 1'b0};

        do_reset();

        // Isolated requests: latency from request to trigger and from ALU ready to done.
        foreach (vecs[i]) begin
            alu_delay = vecs[i].delay;
            e         = '{vecs[i].res, vecs[i].bt, vecs[i].bnt};
            apply_stimulus(vecs[i].id, vecs[i].op, vecs[i].opnds, e, 1'b1);
            req_cyc = cyc;
            tick();
            check_output("busy_after_request", 128'({oBusy1, oBusy0}),
                         128'((vecs[i].id == 0) ? 2'b01 : 2'b10));
            wait_drain(40, "vector_drain");
            check_output("trigger_latency", 128'(last_trig - req_cyc), 128'(2));
            check_output("done_latency", 128'(last_done - last_ready), 128'(1));
        end

        // Ties after reset go to requester 0, and again after requester 1 was served last.
        do_reset();
        alu_delay = 3;
        request(0, OP_ADD, pack6(32'd20, 32'd22, 32'd1, 32'd1, 32'd2, 32'd2));
        request(1, OP_SUB, pack6(32'd50, 32'd8, 32'd3, 32'd1, 32'd9, 32'd9));
        wait_drain(60, "tie_drain");
        check_order(0, "tie_first");
        check_order(1, "tie_second");
        request(0, OP_SUB, pack6(32'd7, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0));
        request(1, OP_ADD, pack6(32'd7, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0));
        wait_drain(60, "tie2_drain");
        check_order(0, "tie2_first");
        check_order(1, "tie2_second");

        // Both requesters re-request on each of their done pulses.
        issued = 2;
        budget = 0;
        request(0, OP_ADD, pack6(32'd100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5));
        request(1, OP_SUB, pack6(32'd200, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5));
        while ((issued < 8 || exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 400) begin
            tick();
            budget++;
            if (oDone0 && issued < 8) begin
                request(0, OP_ADD, pack6(32'(issued), 32'd1000, 32'd5, 32'(issued), 32'd0, 32'd1));
                issued++;
            end else if (oDone1 && issued < 8) begin
                request(1, OP_SUB, pack6(32'd1000, 32'(issued), 32'(issued), 32'd5, 32'd3, 32'd1));
                issued++;
            end
        end
        if (issued < 8 || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            report_fail("alternation_drain", "timeout waiting for completions");
            exp_q0.delete();
            exp_q1.delete();
        end
        for (int k = 0; k < 8; k++) check_order(k % 2, "alternation_order");
        check_output("no_error_on_done_rerequest", 128'(oError), 128'(0));
        wait_drain(20, "alternation_idle");

        // A repeated request while busy is dropped and flags an error; the original op is untouched.
        do_reset();
        request(1, OP_ADD, pack6(32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12));
        tick();
        check_output("error_before_violation", 128'(oError), 128'(0));
        apply_stimulus(1, OP_SUB, pack6(32'd99, 32'd98, 32'd97, 32'd96, 32'd95, 32'd94),
                       alu_model(OP_SUB, pack6(32'd99, 32'd98, 32'd97, 32'd96, 32'd95, 32'd94)), 1'b0);
        tick();
        check_output("error_on_busy_request", 128'(oError), 128'(1));
        wait_drain(40, "busy_request_drain");
        check_output("error_sticky_after_done", 128'(oError), 128'(1));

        do_reset();
        tb_spurious = 1'b1;
        tick();
        check_output("error_on_spurious_ready", 128'(oError), 128'(1));
        check_output("spurious_result_ignored", 128'(oResult), 128'(0));
        repeat (5) tick();
        check_output("error_sticky", 128'(oError), 128'(1));
        check_output("spurious_no_busy", 128'({oBusy1, oBusy0}), 128'(0));

        // Branch flags follow requester 1's result and persist until the next completion.
        do_reset();
        request(1, OP_BEQ, pack6(32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0));
        wait_drain(40, "branch_drain");
        repeat (3) tick();
        check_output("branch_taken_held", 128'({oBranchTaken, oBranchNotTaken}), 128'(2'b10));
        request(0, OP_ADD, pack6(32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0));
        wait_drain(40, "branch_overwrite_drain");
        check_output("branch_overwritten", 128'({oBranchTaken, oBranchNotTaken}), 128'(2'b00));
        check_order(1, "branch_order_first");
        check_order(0, "branch_order_second");

        // Reset while one op waits on the ALU and the other is still pending.
        do_reset();
        alu_delay = 10;
        request(0, OP_ADD, pack6(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1));
        request(1, OP_ADD, pack6(32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2));
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!oALUTrigger && budget < 10);
        if (!oALUTrigger) report_fail("reset_wait_trigger", "no trigger before mid-flight reset");
        tick();
        Reset = 1'b1;
        tick();
        check_zero_outputs("reset_in_wait");
        Reset = 1'b0;
        clear_scoreboard();
        repeat (15) tick();
        check_output("reset_discarded_work", 128'({oBusy1, oBusy0, oALUTrigger}), 128'(0));
        alu_delay = 3;
        request(1, OP_SUB, pack6(32'd9, 32'd4, 32'd8, 32'd8, 32'd1, 32'd2));
        wait_drain(40, "after_reset_drain");
        check_order(1, "after_reset_order");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
